// File: rtl/senal_defs.sv
// Shared event codes and field widths for the senal toggle-event decoder.
// The timestamp width is used only when SENAL_EVT_TIMESTAMP_EN is defined.
package senal_defs;

    localparam int EVT_W = 3;
    localparam int TS_W  = 16;
    localparam int NSRC  = 6;

    typedef enum logic [EVT_W-1:0] {
        EVT_NONE     = 3'd0,
        EVT_RESET    = 3'd1,
        EVT_TEST     = 3'd2,
        EVT_ENERGIA  = 3'd3,
        EVT_MEDICINA = 3'd4,
        EVT_ULTRA    = 3'd5,
        EVT_FOT      = 3'd6
    } evt_code_e;

endpackage

// File: rtl/senal_evt_fifo.sv
// First-word-fall-through event queue with flush; dout reads as zero while empty.
// A flush with a simultaneous push leaves exactly the pushed word in the queue.
module senal_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    wr_addr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty && !flush;
    // Pushing into a full queue is legal when the head leaves on the same edge.
    assign do_push = push && (flush || !full || do_pop);
    assign wr_addr = flush ? '0 : wr_ptr;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_addr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= do_push ? AW'(1) : '0;
            count  <= do_push ? CW'(1) : '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/senal_event_decoder.sv
// Synchronises six toggle lines, turns every level change into a prioritised queued event.
// Define SENAL_EVT_TIMESTAMP_EN to stamp each event with a free-running 16-bit tick (evt_time).
module senal_event_decoder
    import senal_defs::*;
#(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             senal_reset,
    input  logic             senal_test,
    input  logic             senal_energia,
    input  logic             senal_medicina,
    input  logic             senal_ultrasonido,
    input  logic             senal_fot,
    output logic             evt_valid,
    output logic [EVT_W-1:0] evt_code,
    input  logic             evt_ready,
    output logic             overflow
`ifdef SENAL_EVT_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]  evt_time
`endif
);
`ifdef SENAL_EVT_TIMESTAMP_EN
    localparam int FW = EVT_W + TS_W;
`else
    localparam int FW = EVT_W;
`endif
    localparam int WW = $clog2(SYNC_STAGES + 2);

    logic [NSRC-1:0]  raw;
    logic [NSRC-1:0]  sync_q [SYNC_STAGES];
    logic [NSRC-1:0]  prev;
    logic [NSRC-1:0]  chg;
    logic [NSRC-1:0]  pending;
    logic [NSRC-1:0]  win;
    logic [EVT_W-1:0] win_code;
    logic [WW-1:0]    warm;
    logic [FW-1:0]    fifo_din;
    logic [FW-1:0]    fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             any;
    logic             is_reset;
    logic             pop;
    logic             push;
    logic             flush;
    logic             drop;

    assign raw = {senal_fot, senal_ultrasonido, senal_medicina,
                  senal_energia, senal_test, senal_reset};

    // Bit 0 (RESET) has highest priority, so the lowest set bit wins.
    always_comb begin
        win      = '0;
        win_code = EVT_NONE;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pending[i]) begin
                win      = '0;
                win[i]   = 1'b1;
                win_code = EVT_W'(i + 1);
            end
        end
    end

    assign any      = |pending;
    assign is_reset = win[0];
    assign pop      = evt_valid && evt_ready;
    assign flush    = any && is_reset;
    assign push     = any && (is_reset || !fifo_full || pop);
    assign drop     = any && !is_reset && fifo_full && !pop;

    // warm keeps edge detection off until the synchroniser holds real input levels,
    // so a line already high when reset releases is learned rather than reported.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev     <= '0;
            chg      <= '0;
            pending  <= '0;
            overflow <= 1'b0;
            warm     <= WW'(SYNC_STAGES + 1);
        end else begin
            sync_q[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev <= sync_q[SYNC_STAGES-1];
            if (warm != '0) begin
                warm <= warm - WW'(1);
                chg  <= '0;
            end else begin
                chg <= sync_q[SYNC_STAGES-1] ^ prev;
            end
            pending <= (pending & ~win) | chg;
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef SENAL_EVT_TIMESTAMP_EN
    logic [TS_W-1:0] tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            tick <= '0;
        end else begin
            tick <= tick + TS_W'(1);
        end
    end

    assign fifo_din = {tick, win_code};
    assign evt_time = fifo_dout[FW-1:EVT_W];
`else
    assign fifo_din = win_code;
`endif

    senal_evt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign evt_valid = !fifo_empty;
    assign evt_code  = fifo_dout[EVT_W-1:0];

endmodule

// File: tb/tb_senal_event_decoder.sv
// Bench for senal_event_decoder: vector table plus hand sequences, scoreboard on handshakes.
// Timestamp checks run only when SENAL_EVT_TIMESTAMP_EN is defined.
module tb_senal_event_decoder;
    import senal_defs::*;

    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int NV    = 7;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [5:0]       lvl = '0;
    logic             evt_valid;
    logic [EVT_W-1:0] evt_code;
    logic             evt_ready = 1'b0;
    logic             overflow;
`ifdef SENAL_EVT_TIMESTAMP_EN
    logic [TS_W-1:0]  evt_time;
`endif

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    typedef struct {
        logic [5:0] flip;
        int         n;
        int         c [6];
        int         ovf;
    } vec_t;

    vec_t vecs [NV];

    senal_event_decoder #(
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .senal_reset       (lvl[0]),
        .senal_test        (lvl[1]),
        .senal_energia     (lvl[2]),
        .senal_medicina    (lvl[3]),
        .senal_ultrasonido (lvl[4]),
        .senal_fot         (lvl[5]),
        .evt_valid         (evt_valid),
        .evt_code          (evt_code),
        .evt_ready         (evt_ready),
        .overflow          (overflow)
`ifdef SENAL_EVT_TIMESTAMP_EN
        ,
        .evt_time          (evt_time)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Every accepted handshake is compared against the oldest expected code.
    always @(negedge clk) begin
        if (!reset && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: actual=%0d required=none", evt_code);
            end else begin
                check("popped_code", int'(evt_code), exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        exp_q.delete();
        cyc(SYNC + 3);
    endtask

    task automatic flip(input logic [5:0] m);
        lvl = lvl ^ m;
    endtask

    task automatic drain();
        int i;
        i = 0;
        evt_ready = 1'b1;
        while (exp_q.size() != 0 && i < 40) begin
            cyc(1);
            i++;
        end
        check("drain_done", exp_q.size(), 0);
        cyc(2);
        check("drain_valid", int'(evt_valid), 0);
        evt_ready = 1'b0;
    endtask

    initial begin
        int rise;
        int after;
        int seen;
`ifdef SENAL_EVT_TIMESTAMP_EN
        int t1;
        int t2;
`endif
        vecs[0] = '{6'b000100, 1, '{3, 0, 0, 0, 0, 0}, 0};
        vecs[1] = '{6'b101010, 3, '{2, 4, 6, 0, 0, 0}, 0};
        vecs[2] = '{6'b111110, 4, '{2, 3, 4, 5, 0, 0}, 1};
        vecs[3] = '{6'b000001, 1, '{1, 0, 0, 0, 0, 0}, 0};
        vecs[4] = '{6'b000111, 3, '{1, 2, 3, 0, 0, 0}, 0};
        vecs[5] = '{6'b111111, 4, '{1, 2, 3, 4, 0, 0}, 1};
        vecs[6] = '{6'b110000, 2, '{5, 6, 0, 0, 0, 0}, 0};

        cyc(2);
        check("reset_valid", int'(evt_valid), 0);
        check("reset_code", int'(evt_code), 0);
        check("reset_ovf", int'(overflow), 0);
        do_reset();

        // Latency and one-cycle pulse with the consumer always ready.
        evt_ready = 1'b1;
        flip(6'b000100);
        exp_q.push_back(EVT_ENERGIA);
        rise  = -1;
        after = -1;
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            if (evt_valid && rise < 0) rise = k;
            if (k == SYNC + 3) after = int'(evt_valid);
        end
        check("latency", rise, SYNC + 2);
        check("pulse_width", after, 0);
        flip(6'b000100);
        exp_q.push_back(EVT_ENERGIA);
        cyc(14);
        check("falling_edge_evt", exp_q.size(), 0);
        evt_ready = 1'b0;

        for (int v = 0; v < NV; v++) begin
            do_reset();
            evt_ready = 1'b0;
            flip(vecs[v].flip);
            for (int j = 0; j < vecs[v].n; j++) exp_q.push_back(vecs[v].c[j]);
            cyc(14);
            check("vec_head", int'(evt_code), vecs[v].c[0]);
            check("vec_ovf", int'(overflow), vecs[v].ovf);
            drain();
            check("vec_ovf_after", int'(overflow), vecs[v].ovf);
        end

        // Reset override flushes a full queue of 3/4 and leaves overflow clear.
        do_reset();
        flip(6'b000100); cyc(8);
        flip(6'b001000); cyc(8);
        flip(6'b000100); cyc(8);
        flip(6'b001000); cyc(8);
        check("full_head", int'(evt_code), EVT_ENERGIA);
        check("full_ovf", int'(overflow), 0);
        flip(6'b000001);
        exp_q.push_back(EVT_RESET);
        cyc(10);
        check("override_valid", int'(evt_valid), 1);
        check("override_code", int'(evt_code), EVT_RESET);
        check("override_ovf", int'(overflow), 0);
        drain();

        // Backpressure hold, then reset mid-stream with lines held high.
        do_reset();
        flip(6'b111110);
        exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4); exp_q.push_back(5);
        cyc(14);
        check("bp_ovf", int'(overflow), 1);
        for (int k = 0; k < 10; k++) begin
            check("bp_code", int'(evt_code), EVT_TEST);
            check("bp_valid", int'(evt_valid), 1);
            cyc(1);
        end
        reset = 1'b1;
        lvl   = 6'h3F;
        cyc(1);
        check("midreset_valid", int'(evt_valid), 0);
        check("midreset_ovf", int'(overflow), 0);
        check("midreset_code", int'(evt_code), 0);
        reset = 1'b0;
        exp_q.delete();
        evt_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            if (evt_valid) seen = 1;
        end
        check("held_high_no_evt", seen, 0);
        evt_ready = 1'b0;

`ifdef SENAL_EVT_TIMESTAMP_EN
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            if (pass == 1) cyc(65500);
            flip(6'b000100);
            exp_q.push_back(EVT_ENERGIA);
            cyc(100);
            flip(6'b000010);
            exp_q.push_back(EVT_TEST);
            cyc(14);
            t1 = int'(evt_time);
            evt_ready = 1'b1;
            cyc(1);
            evt_ready = 1'b0;
            t2 = int'(evt_time);
            check("ts_delta", (t2 - t1) & 16'hFFFF, 100);
            if (pass == 1) check("ts_wrapped", int'(t2 < t1), 1);
            drain();
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
